starfield_parallax: RTL and testbench



---
 rtl/starfield_pkg.sv | 20 ++
 rtl/starfield_layer.sv | 67 ++++++
 rtl/starfield_parallax.sv | 115 +++++++++++
 tb/tb_starfield_parallax.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/starfield_pkg.sv
// Shared constants, FSM state type and LFSR step function for the parallax starfield.
package starfield_pkg;

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] TAPS      = 16'hB400;
    localparam logic [15:0] SEED_BASE = 16'hACE1;
    localparam logic [15:0] SEED_STEP = 16'h1F35;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        LOAD = 2'd2
    } state_e;

    // Galois right-shift step; a nonzero state never reaches zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/starfield_layer.sv
// One star layer: frame-start state, running scan state and the per-frame skip counter.
module starfield_layer
    import starfield_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED    = SEED_BASE,
    parameter int                SPD_W   = 4,
    parameter int                DENS    = 7,
    parameter bit                NEAREST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_run,
    input  logic             skip,
    input  logic             load,
    input  logic             start,
    input  logic [SPD_W-1:0] start_cnt,
    output logic             star,
    output logic [2:0]       colour,
    output logic             cnt_zero
);

    logic [LFSR_W-1:0] base_q, base_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [SPD_W-1:0]  cnt_q,  cnt_d;

    // Next-state for the skip counter, frame base and scan state.
    always_comb begin
        base_d = base_q;
        cnt_d  = cnt_q;
        lfsr_d = lfsr_q;
        if (start) begin
            cnt_d = start_cnt;
        end else if (skip && (cnt_q != '0)) begin
            base_d = lfsr_next(base_q);
            cnt_d  = cnt_q - SPD_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (load) begin
            lfsr_d = base_q;
        end else if (step_run) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Layer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= SEED;
            lfsr_q <= SEED;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign star     = &lfsr_q[LFSR_W-1 -: DENS];
    assign cnt_zero = (cnt_q == '0);
    // Far layers take colour from the low state bits, never black.
    assign colour   = NEAREST ? 3'b111
                    : ((lfsr_q[2:0] == 3'b000) ? 3'b001 : lfsr_q[2:0]);

endmodule

// File: rtl/starfield_parallax.sv
// Multi-layer parallax starfield: per-frame skip sequencer, layer priority mux, registered colour.
module starfield_parallax
    import starfield_pkg::*;
#(
    parameter int NLAYERS = 3,
    parameter int SPD_W   = 4,
    parameter int DENS    = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     display_on,
    input  logic                     frame_start,
    input  logic                     pause,
    input  logic [NLAYERS*SPD_W-1:0] speed,
    output logic [2:0]               rgb,
    output logic                     star_on,
    output logic                     busy
);

    state_e                    state_q, state_d;
    logic                      step_run_s, skip_s, load_s, start_s;
    logic [NLAYERS-1:0]        star_s, cnt_zero_s;
    logic [NLAYERS-1:0][2:0]   colour_s;
    logic [2:0]                win_s, rgb_d, rgb_q;
    logic                      any_s, star_on_d, star_on_q, busy_d, busy_q;

    // Sequencer: scan in IDLE, advance frame bases in SKIP, restart scans in LOAD.
    always_comb begin
        state_d    = state_q;
        step_run_s = 1'b0;
        skip_s     = 1'b0;
        load_s     = 1'b0;
        start_s    = 1'b0;
        case (state_q)
            IDLE: begin
                step_run_s = display_on;
                if (frame_start) begin
                    start_s = 1'b1;
                    state_d = SKIP;
                end else begin
                    state_d = IDLE;
                end
            end
            SKIP: begin
                skip_s = 1'b1;
                if (&cnt_zero_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = SKIP;
                end
            end
            LOAD: begin
                load_s  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < NLAYERS; k++) begin : g_layer
        starfield_layer #(
            .SEED    (SEED_BASE ^ LFSR_W'(k * SEED_STEP)),
            .SPD_W   (SPD_W),
            .DENS    (DENS),
            .NEAREST (k == 0)
        ) u_layer (
            .clk       (clk),
            .reset     (reset),
            .step_run  (step_run_s),
            .skip      (skip_s),
            .load      (load_s),
            .start     (start_s),
            .start_cnt (pause ? '0 : speed[k*SPD_W +: SPD_W]),
            .star      (star_s[k]),
            .colour    (colour_s[k]),
            .cnt_zero  (cnt_zero_s[k])
        );
    end

    // Lowest-index layer with a star wins; scan from far to near so near overwrites.
    always_comb begin
        win_s = 3'b000;
        any_s = |star_s;
        for (int k = NLAYERS - 1; k >= 0; k--) begin
            if (star_s[k]) begin
                win_s = colour_s[k];
            end else begin
                win_s = win_s;
            end
        end
        star_on_d = display_on && any_s;
        rgb_d     = star_on_d ? win_s : 3'b000;
        busy_d    = (state_d != IDLE);
    end

    // FSM state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rgb_q     <= 3'b000;
            star_on_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rgb_q     <= rgb_d;
            star_on_q <= star_on_d;
            busy_q    <= busy_d;
        end
    end

    assign rgb     = rgb_q;
    assign star_on = star_on_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_starfield_parallax.sv
// Self-checking bench: small raster, per-pixel reference model of each layer's scan position.
module tb_starfield_parallax;

    localparam int NL = 3, SW = 4, DN = 3, SPW = NL * SW;
    localparam int W = 24, HB = 6, LINES = 6, VB = 24;

    logic           clk = 1'b0;
    logic           reset = 1'b1, display_on = 1'b0, frame_start = 1'b0, pause = 1'b0;
    logic [SPW-1:0] speed = '0;
    logic [2:0]     rgb;
    logic           star_on, busy;

    always #5 clk = ~clk;

    starfield_parallax #(.NLAYERS(NL), .SPD_W(SW), .DENS(DN)) dut (
        .clk(clk), .reset(reset), .display_on(display_on), .frame_start(frame_start),
        .pause(pause), .speed(speed), .rgb(rgb), .star_on(star_on), .busy(busy)
    );

    int tests = 0, fails = 0;

    logic [15:0] m_base [NL];
    logic [15:0] m_cur  [NL];
    int          m_busy_left = 0;
    logic [2:0]  m_rgb = 3'b000;
    logic        m_star = 1'b0;
    logic [2:0]  want_rgb, obs_rgb;
    logic        want_star, want_busy, obs_star, obs_busy;

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] ref_adv(input logic [15:0] s, input int n);
        logic [15:0] r = s;
        for (int i = 0; i < n; i++) r = ref_step(r);
        return r;
    endfunction

    function automatic logic [15:0] ref_seed(input int k);
        return 16'hACE1 ^ 16'(k * 16'h1F35);
    endfunction

    function automatic bit ref_star(input logic [15:0] s);
        return (int'(s >> (16 - DN)) == ((1 << DN) - 1));
    endfunction

    function automatic logic [2:0] ref_colour(input int k, input logic [15:0] s);
        if (k == 0) return 3'b111;
        return (s[2:0] == 3'b000) ? 3'b001 : s[2:0];
    endfunction

    function automatic int field(input logic [SPW-1:0] sp, input int k);
        return int'(sp[k*SW +: SW]);
    endfunction

    function automatic int max_field(input logic [SPW-1:0] sp);
        int m = 0;
        for (int k = 0; k < NL; k++) if (field(sp, k) > m) m = field(sp, k);
        return m;
    endfunction

    // One clock: capture outputs of the previous cycle, drive this cycle, advance the model.
    task automatic cycle(input logic ds, input logic fs, input logic rst,
                         input logic ps, input logic [SPW-1:0] sp);
        bit         hit;
        logic [2:0] col;
        int         mx, n;
        @(negedge clk);
        obs_rgb = rgb;  obs_star = star_on;  obs_busy = busy;
        want_rgb = m_rgb;  want_star = m_star;  want_busy = (m_busy_left > 0);
        display_on = ds; frame_start = fs; reset = rst; pause = ps; speed = sp;
        if (rst) begin
            for (int k = 0; k < NL; k++) begin
                m_base[k] = ref_seed(k);
                m_cur[k]  = m_base[k];
            end
            m_busy_left = 0; m_rgb = 3'b000; m_star = 1'b0;
        end else begin
            hit = 1'b0; col = 3'b000;
            for (int k = NL - 1; k >= 0; k--)
                if (ref_star(m_cur[k])) begin hit = 1'b1; col = ref_colour(k, m_cur[k]); end
            m_star = ds && hit;
            m_rgb  = m_star ? col : 3'b000;
            if (m_busy_left > 0) begin
                m_busy_left--;
            end else begin
                if (ds) for (int k = 0; k < NL; k++) m_cur[k] = ref_step(m_cur[k]);
                if (fs) begin
                    mx = 0;
                    for (int k = 0; k < NL; k++) begin
                        n = ps ? 0 : field(sp, k);
                        if (n > mx) mx = n;
                        m_base[k] = ref_adv(m_base[k], n);
                        m_cur[k]  = m_base[k];
                    end
                    m_busy_left = mx + 2;
                end
            end
        end
    endtask

    // Visible lines then vertical blank with frame_start; optional extra pulse / reset inside blank.
    task automatic run_frame(input logic [SPW-1:0] fs_speed, input logic fs_pause, input bit scramble,
                             input int exp_len, input int extra_fs_at, input int reset_at,
                             input string tag);
        int             blen = 0;
        logic [SPW-1:0] sp;
        for (int y = 0; y < LINES; y++) begin
            for (int x = 0; x < W + HB; x++) begin
                sp = scramble ? SPW'($urandom) : fs_speed;
                cycle(x < W, 1'b0, 1'b0, fs_pause, sp);
                tests++;
                if (obs_rgb !== want_rgb || obs_star !== want_star || obs_busy !== want_busy) begin
                    fails++;
                    $display("FAIL %s pixel y=%0d x=%0d: rgb/star/busy got %b/%b/%b want %b/%b/%b",
                             tag, y, x, obs_rgb, obs_star, obs_busy, want_rgb, want_star, want_busy);
                end
            end
        end
        for (int v = 0; v < VB; v++) begin
            sp = (v == 0 || !scramble) ? fs_speed : SPW'($urandom);
            cycle(1'b0, (v == 0) || (v == extra_fs_at), v == reset_at, fs_pause, sp);
            if (obs_busy === 1'b1) blen++;
            tests++;
            if (obs_rgb !== want_rgb || obs_star !== want_star || obs_busy !== want_busy) begin
                fails++;
                $display("FAIL %s blank v=%0d: rgb/star/busy got %b/%b/%b want %b/%b/%b",
                         tag, v, obs_rgb, obs_star, obs_busy, want_rgb, want_star, want_busy);
            end
        end
        tests++;
        if (blen !== exp_len) begin
            fails++;
            $display("FAIL %s busy_len: got %0d want %0d", tag, blen, exp_len);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            cycle(i < 3, 1'b0, i < 3, 1'b0, '0);
            if (i > 0) begin
                tests++;
                if (obs_rgb !== 3'b000 || obs_star !== 1'b0 || obs_busy !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_outputs cycle %0d: rgb/star/busy got %b/%b/%b want 000/0/0",
                             i, obs_rgb, obs_star, obs_busy);
                end
            end
        end
        run_frame('0, 1'b0, 1'b0, 2, -1, -1, "reset_seed_frame");
    endtask

    task automatic test_static;
        for (int f = 0; f < 2; f++) run_frame('0, 1'b0, 1'b0, 2, -1, -1, "static");
    endtask

    task automatic test_scroll;
        for (int f = 0; f < 3; f++) run_frame(SPW'(3), 1'b0, 1'b0, 5, -1, -1, "scroll");
    endtask

    task automatic test_pause;
        run_frame({SPW{1'b1}}, 1'b1, 1'b0, 2, -1, -1, "pause_on");
        run_frame({SPW{1'b1}}, 1'b0, 1'b0, 17, -1, -1, "pause_off");
        run_frame('0, 1'b0, 1'b0, 2, -1, -1, "pause_after");
    endtask

    task automatic test_random;
        logic [SPW-1:0] sp;
        logic           ps;
        for (int f = 0; f < 8; f++) begin
            sp = SPW'($urandom);
            ps = ($urandom_range(0, 3) == 0);
            run_frame(sp, ps, 1'b1, ps ? 2 : max_field(sp) + 2, -1, -1, "random");
        end
    endtask

    task automatic test_abuse;
        run_frame(SPW'(5), 1'b0, 1'b0, 7, 2, -1, "fs_in_skip");
        run_frame('0, 1'b0, 1'b0, 2, -1, -1, "fs_in_skip_next");
        run_frame(SPW'(9) | (SPW'(4) << SW), 1'b0, 1'b0, 2, -1, 2, "reset_in_skip");
        run_frame('0, 1'b0, 1'b0, 2, -1, -1, "reset_in_skip_next");
    endtask

    initial begin
        test_reset;
        test_static;
        test_scroll;
        test_pause;
        test_random;
        test_abuse;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
